ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 134 +++++++++++++
 tb/tb_ram_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - two-requester arbiter for a single-port RAM with lock and hold limit
module ram_arbiter #(
  parameter int SIZE     = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic            m0_lock,
  input  logic [SIZE-1:0] m0_addr,
  input  logic [15:0]     m0_wdata,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic            m1_lock,
  input  logic [SIZE-1:0] m1_addr,
  input  logic [15:0]     m1_wdata,
  output logic            m0_gnt,
  output logic            m1_gnt,
  output logic            m0_rvalid,
  output logic            m1_rvalid,
  output logic [15:0]     m0_rdata,
  output logic [15:0]     m1_rdata,
  output logic            ram_wrEn,
  output logic [SIZE-1:0] ram_addr,
  output logic [15:0]     ram_wdata,
  input  logic [15:0]     ram_rdata
);

  localparam logic [3:0] HOLD_MAX = 4'(MAX_HOLD);

  // last winner, lock owner, hold counter, pending read and held address
  logic            last_q, last_d;
  logic            lock_q, lock_d;
  logic            lock_id_q, lock_id_d;
  logic [3:0]      hold_q, hold_d;
  logic            rd_pend_q, rd_pend_d;
  logic            rd_id_q, rd_id_d;
  logic [SIZE-1:0] addr_q, addr_d;

  logic            gnt0, gnt1, pick;
  logic            any_gnt, win_id, win_we, win_lock;
  logic [SIZE-1:0] win_addr;
  logic [15:0]     win_wdata;

  // choose the winner: single requester wins outright, contention goes to the
  // lock owner until it has used up its hold budget, otherwise round-robin
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    pick = 1'b0;
    if (rst) begin
      if (m0_req && m1_req) begin
        if (lock_q) begin
          pick = (hold_q >= HOLD_MAX) ? ~lock_id_q : lock_id_q;
        end else begin
          pick = ~last_q;
        end
        gnt0 = ~pick;
        gnt1 = pick;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
  end

  assign any_gnt   = gnt0 | gnt1;
  assign win_id    = gnt1;
  assign win_we    = gnt1 ? m1_we    : m0_we;
  assign win_lock  = gnt1 ? m1_lock  : m0_lock;
  assign win_addr  = gnt1 ? m1_addr  : m0_addr;
  assign win_wdata = gnt1 ? m1_wdata : m0_wdata;

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign ram_wrEn  = any_gnt & win_we;
  assign ram_addr  = any_gnt ? win_addr : addr_q;
  assign ram_wdata = win_wdata;
  // a read launched just before reset must not surface while reset is held
  assign m0_rvalid = rst & rd_pend_q & ~rd_id_q;
  assign m1_rvalid = rst & rd_pend_q &  rd_id_q;
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

  // next state: lock survives only while the winner keeps asserting lock;
  // hold counts consecutive locked grants and saturates at the limit
  always_comb begin
    last_d    = last_q;
    lock_d    = 1'b0;
    lock_id_d = lock_id_q;
    hold_d    = 4'd0;
    rd_pend_d = 1'b0;
    rd_id_d   = rd_id_q;
    addr_d    = addr_q;
    if (any_gnt) begin
      last_d    = win_id;
      addr_d    = win_addr;
      rd_pend_d = ~win_we;
      rd_id_d   = win_id;
      if (win_lock) begin
        lock_d    = 1'b1;
        lock_id_d = win_id;
        if (lock_q && (lock_id_q == win_id)) begin
          hold_d = (hold_q >= HOLD_MAX) ? hold_q : hold_q + 4'd1;
        end else begin
          hold_d = 4'd1;
        end
      end
    end
  end

  // state registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      lock_id_q <= 1'b0;
      hold_q    <= 4'd0;
      rd_pend_q <= 1'b0;
      rd_id_q   <= 1'b0;
      addr_q    <= '0;
    end else begin
      last_q    <= last_d;
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      hold_q    <= hold_d;
      rd_pend_q <= rd_pend_d;
      rd_id_q   <= rd_id_d;
      addr_q    <= addr_d;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - self-checking bench for ram_arbiter
module tb_ram_arbiter;

  localparam int SIZE     = 8;
  localparam int MAX_HOLD = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [SIZE-1:0] m0_addr, m1_addr;
  logic [15:0]     m0_wdata, m1_wdata;
  logic            m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [15:0]     m0_rdata, m1_rdata;
  logic            ram_wrEn;
  logic [SIZE-1:0] ram_addr;
  logic [15:0]     ram_wdata;
  logic [15:0]     ram_rdata;

  int n_cmp = 0;
  int n_err = 0;

  ram_arbiter #(.SIZE(SIZE), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_wrEn(ram_wrEn), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // single-port synchronous RAM attached to the arbiter
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (ram_wrEn) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: arbitration rules, lock/hold budget, memory contents, pending read
  logic [15:0] model_mem [256];
  bit          model_ok = 1'b0;
  int          m_last = 1, m_owner = -1, m_hold = 0, m_pend = -1;
  logic [15:0] m_pend_data;
  logic [7:0]  m_hold_addr = 8'd0;
  int          win;
  logic        w_we, w_lock;
  logic [7:0]  w_addr, e_addr;
  logic [15:0] w_data;

  always @(negedge clk) begin
    win = -1;
    if (rst === 1'b1) begin
      if (m0_req && m1_req) begin
        if (m_owner >= 0) win = (m_hold >= MAX_HOLD) ? 1 - m_owner : m_owner;
        else win = 1 - m_last;
      end else if (m0_req) win = 0;
      else if (m1_req) win = 1;
    end
    w_we   = (win == 1) ? m1_we    : m0_we;
    w_lock = (win == 1) ? m1_lock  : m0_lock;
    w_addr = (win == 1) ? m1_addr  : m0_addr;
    w_data = (win == 1) ? m1_wdata : m0_wdata;
    e_addr = (win >= 0) ? w_addr : m_hold_addr;
    if (model_ok) begin
      check("gnt0", 32'(m0_gnt), 32'(win == 0));
      check("gnt1", 32'(m1_gnt), 32'(win == 1));
      check("wren", 32'(ram_wrEn), 32'(win >= 0 && w_we));
      check("ram_addr", 32'(ram_addr), 32'(e_addr));
      if (win >= 0) check("ram_wdata", 32'(ram_wdata), 32'(w_data));
      check("rvalid0", 32'(m0_rvalid), 32'(rst && m_pend == 0));
      check("rvalid1", 32'(m1_rvalid), 32'(rst && m_pend == 1));
      if (rst && m_pend == 0) check("rdata0", 32'(m0_rdata), 32'(m_pend_data));
      if (rst && m_pend == 1) check("rdata1", 32'(m1_rdata), 32'(m_pend_data));
    end
    if (rst !== 1'b1) begin
      m_last = 1; m_owner = -1; m_hold = 0; m_pend = -1; m_hold_addr = 8'd0;
      model_ok = 1'b1;
    end else if (win >= 0) begin
      m_last = win;
      m_hold_addr = w_addr;
      m_pend = w_we ? -1 : win;
      m_pend_data = model_mem[w_addr];
      if (w_we) model_mem[w_addr] = w_data;
      if (w_lock) begin
        m_hold = (m_owner == win) ? ((m_hold < MAX_HOLD) ? m_hold + 1 : MAX_HOLD) : 1;
        m_owner = win;
      end else begin
        m_owner = -1; m_hold = 0;
      end
    end else begin
      m_owner = -1; m_hold = 0; m_pend = -1;
    end
  end

  task automatic drive(input logic r0, w0, l0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, w1, l1, input logic [7:0] a1, input logic [15:0] d1);
    m0_req = r0; m0_we = w0; m0_lock = l0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_we = w1; m1_lock = l1; m1_addr = a1; m1_wdata = d1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 16'h0, 0, 0, 0, 8'h00, 16'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle();
    tick();
    rst = 1'b1;
  endtask

  int cnt0, cnt1, streak, wcnt;

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'(i);
      model_mem[i] = 16'(i);
    end
    rst = 1'b0;
    idle();
    tick();
    tick();
    rst = 1'b1;

    // lone read of addr 5 returns 0x0005 to m0 only
    drive(1, 0, 0, 8'd5, 16'h0, 0, 0, 0, 8'd0, 16'h0);
    #1 check("s1_m0_gnt", 32'(m0_gnt), 32'd1);
    check("s1_m1_gnt", 32'(m1_gnt), 32'd0);
    tick();
    idle();
    #1 check("s1_m0_rvalid", 32'(m0_rvalid), 32'd1);
    check("s1_m0_rdata", 32'(m0_rdata), 32'h0005);
    check("s1_m1_rvalid", 32'(m1_rvalid), 32'd0);
    tick();

    // continuous contention alternates starting with m0
    do_reset();
    cnt0 = 0; cnt1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, 0, 8'(8'h10 + i), 16'h0, 1, 0, 0, 8'(8'h20 + i), 16'h0);
      #1 check("s2_m1_turn", 32'(m1_gnt), 32'(i % 2));
      check("s2_m0_turn", 32'(m0_gnt), 32'(1 - (i % 2)));
      if (i > 0) begin
        cnt0 += int'(m0_rvalid);
        cnt1 += int'(m1_rvalid);
      end
      tick();
    end
    idle();
    #1 cnt0 += int'(m0_rvalid);
    cnt1 += int'(m1_rvalid);
    tick();
    check("s2_rvalid_m0", 32'(cnt0), 32'd4);
    check("s2_rvalid_m1", 32'(cnt1), 32'd4);

    // m1 lock: 4 consecutive grants then m0, saturation with m0 idle
    do_reset();
    drive(0, 0, 0, 8'h40, 16'h0, 1, 0, 1, 8'h30, 16'h0);
    #1 check("s3_lock_first", 32'(m1_gnt), 32'd1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 8'h40, 16'h0, 1, 0, 1, 8'h31, 16'h0);
      #1 check("s3_hold_m1", 32'(m1_gnt), 32'(i < 3));
      check("s3_hold_m0", 32'(m0_gnt), 32'(i == 3));
      tick();
    end
    streak = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 8'h40, 16'h0, 1, 0, 1, 8'h32, 16'h0);
      #1 streak += int'(m1_gnt);
      tick();
    end
    check("s3_sat_streak", 32'(streak), 32'd6);
    drive(1, 0, 0, 8'h41, 16'h0, 1, 0, 1, 8'h33, 16'h0);
    #1 check("s3_sat_release", 32'(m0_gnt), 32'd1);
    tick();
    idle();
    tick();

    // write by m1 then read by m0 of the same address
    do_reset();
    wcnt = 0;
    drive(0, 0, 0, 8'd0, 16'h0, 1, 1, 0, 8'd15, 16'h0043);
    #1 wcnt += int'(ram_wrEn);
    tick();
    drive(1, 0, 0, 8'd15, 16'h0, 0, 0, 0, 8'd0, 16'h0);
    #1 wcnt += int'(ram_wrEn);
    check("s4_m0_gnt", 32'(m0_gnt), 32'd1);
    tick();
    idle();
    #1 wcnt += int'(ram_wrEn);
    check("s4_rvalid", 32'(m0_rvalid), 32'd1);
    check("s4_rdata", 32'(m0_rdata), 32'h0043);
    tick();
    check("s4_wren_count", 32'(wcnt), 32'd1);

    // reset drops a lock in progress
    do_reset();
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 8'd0, 16'h0, 1, 0, 1, 8'h50, 16'h0);
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    drive(1, 0, 0, 8'h51, 16'h0, 1, 0, 1, 8'h52, 16'h0);
    #1 check("s5_lock_dropped", 32'(m0_gnt), 32'd1);
    tick();

    // reset the cycle after an m0 read grant
    drive(1, 0, 0, 8'd7, 16'h0, 0, 0, 0, 8'd0, 16'h0);
    #1 check("s5_read_gnt", 32'(m0_gnt), 32'd1);
    tick();
    rst = 1'b0;
    drive(1, 0, 0, 8'd9, 16'h0, 1, 1, 0, 8'd3, 16'hdead);
    #1 check("s5_rst_rvalid0", 32'(m0_rvalid), 32'd0);
    check("s5_rst_rvalid1", 32'(m1_rvalid), 32'd0);
    check("s5_rst_wren", 32'(ram_wrEn), 32'd0);
    check("s5_rst_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    tick();
    rst = 1'b1;
    drive(1, 0, 0, 8'd9, 16'h0, 1, 0, 0, 8'd3, 16'h0);
    #1 check("s5_post_m0", 32'(m0_gnt), 32'd1);
    check("s5_post_m1", 32'(m1_gnt), 32'd0);
    check("s5_post_rvalid", 32'(m0_rvalid), 32'd0);
    tick();
    idle();
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
